// File: rtl/forth_pkg.sv
// -----------------------------------------------------------------------------
// forth_pkg -- shared definitions for the Forth core front end.
//   WORD_W    : machine word width (bits)
//   CODE_BASE : start of code space
//   DICT_BASE : start of dictionary space
//   fetch_state_t : instruction-fetch FSM state encoding
//   pc_incr   : sequential next-fetch address (wraps modulo 2^16)
// -----------------------------------------------------------------------------
package forth_pkg;

    localparam int                 WORD_W    = 16;
    localparam logic [WORD_W-1:0]  CODE_BASE = 16'h0000;
    localparam logic [WORD_W-1:0]  DICT_BASE = 16'h1000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    // Instructions are one 16-bit word, so the next sequential fetch is +2 bytes.
    function automatic logic [WORD_W-1:0] pc_incr(input logic [WORD_W-1:0] addr);
        return addr + 16'd2;
    endfunction

endpackage

// File: rtl/ifetch_rstack.sv
// -----------------------------------------------------------------------------
// ifetch_rstack -- LIFO return-address stack for the fetch unit.
// Parameters:
//   RS_DEPTH : number of entries (power of two, 2..16)
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (clears depth only)
//   push, pop    : push push_data / discard top (caller never asserts both)
//   push_data    : return address to store
//   top          : most recently pushed entry (don't-care when empty)
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
module ifetch_rstack
    import forth_pkg::*;
#(
    parameter int RS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] push_data,
    output logic [WORD_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(RS_DEPTH);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);

    logic [CNT_W-1:0]  depth_r;
    logic [WORD_W-1:0] mem_r [RS_DEPTH];

    assign full  = (depth_r == CNT_W'(RS_DEPTH));
    assign empty = (depth_r == {CNT_W{1'b0}});
    // Top lives one slot below the depth count; the wrap when empty is harmless.
    assign top   = mem_r[PTR_W'(depth_r - CNT_W'(1))];

    // Depth counter: the only stack state that needs a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_r <= {CNT_W{1'b0}};
        end else if (push && !full) begin
            depth_r <= depth_r + CNT_W'(1);
        end else if (pop && !empty) begin
            depth_r <= depth_r - CNT_W'(1);
        end else begin
            depth_r <= depth_r;
        end
    end

    // Storage write: no reset, stale entries above depth are never read as valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_r[PTR_W'(depth_r)] <= push_data;
        end
    end

endmodule

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch -- instruction fetch unit with return-address stack.
// Parameters:
//   RS_DEPTH : return-stack entries (power of two, 2..16)
//   RESET_PC : first fetch address after reset
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   pc / instr          : memory address out, same-cycle instruction word in
//   ir, ir_pc, ir_valid : fetched instruction, its address, live flag
//   ir_ready            : decode consumes ir this cycle
//   redirect, call, ret : control flow (priority ret > call > redirect),
//                         honoured only while ir is valid and consumed
//   redirect_pc         : target for redirect/call
//   rs_overflow         : sticky, call with stack full
//   rs_underflow        : sticky, ret with stack empty
//   misalign            : sticky, odd redirect/call target
// Configuration:
//   IFETCH_ALIGN_CHECK_EN defined  -> odd targets fault and set misalign.
//   IFETCH_ALIGN_CHECK_EN undefined -> bit 0 of the target is cleared,
//                                      misalign never sets.
// Any fault parks the unit in FAULT until reset.
// -----------------------------------------------------------------------------
module ifetch
    import forth_pkg::*;
#(
    parameter int          RS_DEPTH = 8,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] pc,
    input  logic [15:0] instr,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic        call,
    input  logic        ret,
    input  logic [15:0] redirect_pc,
    output logic        rs_overflow,
    output logic        rs_underflow,
    output logic        misalign
);

    fetch_state_t      state_r, state_nxt_s;
    logic [WORD_W-1:0] pc_r, pc_nxt_s;
    logic [WORD_W-1:0] ir_r, ir_nxt_s;
    logic [WORD_W-1:0] ir_pc_r, ir_pc_nxt_s;
    logic              ir_valid_r, ir_valid_nxt_s;
    logic              ovf_r, ovf_nxt_s;
    logic              unf_r, unf_nxt_s;
    logic              mis_r, mis_nxt_s;

    logic              push_s, pop_s;
    logic [WORD_W-1:0] rs_top_s;
    logic              rs_full_s, rs_empty_s;
    logic [WORD_W-1:0] target_s;
    logic              target_odd_s;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign target_s     = redirect_pc;
    assign target_odd_s = redirect_pc[0];
`else
    assign target_s     = redirect_pc & 16'hFFFE;
    assign target_odd_s = 1'b0;
`endif

    ifetch_rstack #(
        .RS_DEPTH (RS_DEPTH)
    ) u_rstack (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_incr(ir_pc_r)),
        .top       (rs_top_s),
        .full      (rs_full_s),
        .empty     (rs_empty_s)
    );

    // Next-state and datapath decisions for the fetch FSM.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        ir_nxt_s       = ir_r;
        ir_pc_nxt_s    = ir_pc_r;
        ir_valid_nxt_s = ir_valid_r;
        ovf_nxt_s      = ovf_r;
        unf_nxt_s      = unf_r;
        mis_nxt_s      = mis_r;
        push_s         = 1'b0;
        pop_s          = 1'b0;

        case (state_r)
            ST_BOOT: begin
                pc_nxt_s       = RESET_PC;
                ir_valid_nxt_s = 1'b0;
                state_nxt_s    = ST_RUN;
            end
            ST_RUN: begin
                if (ir_valid_r && ir_ready) begin
                    // Controls belong to the instruction being consumed now.
                    if (ret) begin
                        ir_valid_nxt_s = 1'b0;
                        if (rs_empty_s) begin
                            unf_nxt_s   = 1'b1;
                            state_nxt_s = ST_FAULT;
                        end else begin
                            pop_s    = 1'b1;
                            pc_nxt_s = rs_top_s;
                        end
                    end else if (call) begin
                        ir_valid_nxt_s = 1'b0;
                        if (rs_full_s) begin
                            ovf_nxt_s   = 1'b1;
                            state_nxt_s = ST_FAULT;
                        end else if (target_odd_s) begin
                            mis_nxt_s   = 1'b1;
                            state_nxt_s = ST_FAULT;
                        end else begin
                            push_s   = 1'b1;
                            pc_nxt_s = target_s;
                        end
                    end else if (redirect) begin
                        ir_valid_nxt_s = 1'b0;
                        if (target_odd_s) begin
                            mis_nxt_s   = 1'b1;
                            state_nxt_s = ST_FAULT;
                        end else begin
                            pc_nxt_s = target_s;
                        end
                    end else begin
                        ir_nxt_s       = instr;
                        ir_pc_nxt_s    = pc_r;
                        ir_valid_nxt_s = 1'b1;
                        pc_nxt_s       = pc_incr(pc_r);
                    end
                end else if (!ir_valid_r) begin
                    ir_nxt_s       = instr;
                    ir_pc_nxt_s    = pc_r;
                    ir_valid_nxt_s = 1'b1;
                    pc_nxt_s       = pc_incr(pc_r);
                end else begin
                    // Decode stalled: everything holds.
                    ir_valid_nxt_s = ir_valid_r;
                end
            end
            ST_FAULT: begin
                ir_valid_nxt_s = 1'b0;
            end
            default: begin
                // Unreachable encoding: park safely.
                ir_valid_nxt_s = 1'b0;
                state_nxt_s    = ST_FAULT;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_BOOT;
            pc_r       <= RESET_PC;
            ir_r       <= 16'h0000;
            ir_pc_r    <= 16'h0000;
            ir_valid_r <= 1'b0;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
            mis_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            ir_r       <= ir_nxt_s;
            ir_pc_r    <= ir_pc_nxt_s;
            ir_valid_r <= ir_valid_nxt_s;
            ovf_r      <= ovf_nxt_s;
            unf_r      <= unf_nxt_s;
            mis_r      <= mis_nxt_s;
        end
    end

    assign pc           = pc_r;
    assign ir           = ir_r;
    assign ir_pc        = ir_pc_r;
    assign ir_valid     = ir_valid_r;
    assign rs_overflow  = ovf_r;
    assign rs_underflow = unf_r;
    assign misalign     = mis_r;

endmodule

// File: tb/tb_ifetch.sv
// -----------------------------------------------------------------------------
// tb_ifetch -- self-checking bench for ifetch.
// A queue-based reference model of the fetch unit is stepped once per clock
// with the same inputs; directed sequences cover the documented scenarios and a
// randomized phase exercises arbitrary stall/control mixes with resets.
// -----------------------------------------------------------------------------
module tb_ifetch;

    localparam int          RS_DEPTH = 8;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int M_BOOT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b1;
    logic        redirect = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        rs_overflow;
    logic        rs_underflow;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int          m_mode;
    logic [15:0] m_pc, m_ir, m_ir_pc;
    logic        m_valid, m_ovf, m_unf, m_mis;
    logic [15:0] m_stack[$];

    always #5 clk = ~clk;

    // Instruction memory: word k holds value k.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a >> 1) & 16'h1FFF;
    endfunction

    assign instr = mem_word(pc);

    ifetch #(
        .RS_DEPTH (RS_DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .instr        (instr),
        .ir           (ir),
        .ir_pc        (ir_pc),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .redirect     (redirect),
        .call         (call),
        .ret          (ret),
        .redirect_pc  (redirect_pc),
        .rs_overflow  (rs_overflow),
        .rs_underflow (rs_underflow),
        .misalign     (misalign)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_BOOT;
        m_pc    = RESET_PC;
        m_ir    = 16'h0000;
        m_ir_pc = 16'h0000;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_mis   = 1'b0;
        m_stack.delete();
    endtask

    task automatic model_fetch();
        m_ir    = mem_word(m_pc);
        m_ir_pc = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 16'd2;
    endtask

    task automatic model_fault();
        m_valid = 1'b0;
        m_mode  = M_FAULT;
    endtask

    // One clock of the reference behaviour, using the inputs presently driven.
    task automatic model_step();
        logic [15:0] tgt;
        logic        odd;
        logic [15:0] ra;
`ifdef IFETCH_ALIGN_CHECK_EN
        tgt = redirect_pc;
        odd = redirect_pc[0];
`else
        tgt = {redirect_pc[15:1], 1'b0};
        odd = 1'b0;
`endif
        if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (!m_valid) begin
                model_fetch();
            end else if (ir_ready) begin
                if (ret) begin
                    if (m_stack.size() == 0) begin
                        m_unf = 1'b1;
                        model_fault();
                    end else begin
                        m_pc    = m_stack.pop_back();
                        m_valid = 1'b0;
                    end
                end else if (call) begin
                    if (m_stack.size() >= RS_DEPTH) begin
                        m_ovf = 1'b1;
                        model_fault();
                    end else if (odd) begin
                        m_mis = 1'b1;
                        model_fault();
                    end else begin
                        ra = m_ir_pc + 16'd2;
                        m_stack.push_back(ra);
                        m_pc    = tgt;
                        m_valid = 1'b0;
                    end
                end else if (redirect) begin
                    if (odd) begin
                        m_mis = 1'b1;
                        model_fault();
                    end else begin
                        m_pc    = tgt;
                        m_valid = 1'b0;
                    end
                end else begin
                    model_fetch();
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("pc", pc, m_pc);
        check_eq("ir_valid", {15'd0, ir_valid}, {15'd0, m_valid});
        check_eq("rs_overflow", {15'd0, rs_overflow}, {15'd0, m_ovf});
        check_eq("rs_underflow", {15'd0, rs_underflow}, {15'd0, m_unf});
        check_eq("misalign", {15'd0, misalign}, {15'd0, m_mis});
        if (m_valid) begin
            check_eq("ir", ir, m_ir);
            check_eq("ir_pc", ir_pc, m_ir_pc);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_ctl();
        redirect = 1'b0;
        call     = 1'b0;
        ret      = 1'b0;
        ir_ready = 1'b1;
    endtask

    // Asynchronous reset between clock edges; values must change without a clock.
    task automatic do_reset();
        clear_ctl();
        reset = 1'b1;
        #2;
        model_reset();
        check_eq("rst_pc", pc, RESET_PC);
        check_eq("rst_ir", ir, 16'h0000);
        check_eq("rst_ir_pc", ir_pc, 16'h0000);
        check_eq("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
        check_eq("rst_flags", {13'd0, rs_overflow, rs_underflow, misalign}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 16 && !m_valid; n++) begin
            tick();
        end
        check_eq("wait_valid", {15'd0, ir_valid}, 16'd1);
    endtask

    task automatic wait_irpc(input logic [15:0] target);
        for (int n = 0; n < 64 && !(m_valid && m_ir_pc == target); n++) begin
            tick();
        end
        check_eq("wait_irpc", ir_pc, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        #1;
        do_reset();

        // Sequential fetch from reset.
        tick();
        check_eq("boot_valid", {15'd0, ir_valid}, 16'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("seq_ir", ir, 16'(k));
            check_eq("seq_ir_pc", ir_pc, 16'(2 * k));
        end

        // Decode stall holds everything, resume is seamless.
        ir_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("stall_ir_pc", ir_pc, 16'h0004);
            check_eq("stall_ir", ir, 16'h0002);
            check_eq("stall_pc", pc, 16'h0006);
        end
        ir_ready = 1'b1;
        tick();
        check_eq("resume_ir_pc", ir_pc, 16'h0006);
        check_eq("resume_ir", ir, 16'h0003);

        // Call and return.
        wait_irpc(16'h0010);
        call = 1'b1; redirect_pc = 16'h1000;
        tick();
        call = 1'b0;
        check_eq("call_bubble", {15'd0, ir_valid}, 16'd0);
        tick();
        check_eq("call_ir_pc", ir_pc, 16'h1000);
        ret = 1'b1;
        tick();
        ret = 1'b0;
        check_eq("ret_pc", pc, 16'h0012);
        tick();
        check_eq("ret_ir_pc", ir_pc, 16'h0012);

        // Address wrap.
        redirect = 1'b1; redirect_pc = 16'hFFFC;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        check_eq("wrap_ir_pc_hi", ir_pc, 16'hFFFE);
        tick();
        check_eq("wrap_ir_pc", ir_pc, 16'h0000);
        check_eq("wrap_pc", pc, 16'h0002);

        // ret beats redirect in the same cycle.
        do_reset();
        wait_irpc(16'h003E);
        call = 1'b1; redirect_pc = 16'h0200;
        tick();
        call = 1'b0;
        wait_irpc(16'h0200);
        ret = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        clear_ctl();
        check_eq("prio_pc", pc, 16'h0040);

        // Nine nested calls overflow an eight-entry stack.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wait_valid();
            call = 1'b1; redirect_pc = 16'h1000 + 16'(i * 32);
            tick();
            call = 1'b0;
        end
        check_eq("ovf_flag", {15'd0, rs_overflow}, 16'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("ovf_valid", {15'd0, ir_valid}, 16'd0);
        end

        // ret with empty stack.
        do_reset();
        wait_valid();
        ret = 1'b1;
        tick();
        ret = 1'b0;
        check_eq("unf_flag", {15'd0, rs_underflow}, 16'd1);
        check_eq("unf_valid", {15'd0, ir_valid}, 16'd0);

        // Odd redirect target.
        do_reset();
        wait_valid();
        redirect = 1'b1; redirect_pc = 16'h0101;
        tick();
        redirect = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        check_eq("odd_misalign", {15'd0, misalign}, 16'd1);
        tick();
        check_eq("odd_valid", {15'd0, ir_valid}, 16'd0);
`else
        check_eq("odd_pc", pc, 16'h0100);
        tick();
        check_eq("odd_ir_pc", ir_pc, 16'h0100);
`endif

        // Reset in the middle of a redirect bubble.
        do_reset();
        wait_valid();
        redirect = 1'b1; redirect_pc = 16'h0300;
        tick();
        redirect = 1'b0;
        do_reset();

        // Randomized phase.
        for (int n = 0; n < 1500; n++) begin
            ir_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 15);
            ret      = (r == 0);
            call     = (r == 1) || (r == 2);
            redirect = (r == 3) || (r == 4);
            if ($urandom_range(0, 9) == 0) begin
                ret      = 1'($urandom_range(0, 1));
                call     = 1'($urandom_range(0, 1));
                redirect = 1'($urandom_range(0, 1));
            end
            redirect_pc = 16'($urandom);
            if ((m_mode == M_FAULT && $urandom_range(0, 7) == 0) ||
                $urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 8: return-stack entries, power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000: first fetch address after reset.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- pc  out  16  byte address to instruction memory (word = pc[13:1]).
- instr  in  16  memory data for pc, combinational same cycle.
- ir  out  16  fetched instruction to decode.
- ir_pc  out  16  address of ir.
- ir_valid  out  1  ir holds a live instruction.
- ir_ready  in  1  decode consumes ir this cycle.
- redirect  in  1  jump/branch to redirect_pc.
- call  in  1  push return address, jump to redirect_pc.
- ret  in  1  pop return address, jump to it.
- redirect_pc  in  16  target for redirect/call.
- rs_overflow  out  1  sticky: call with stack full.
- rs_underflow  out  1  sticky: ret with stack empty.
- misalign  out  1  sticky: odd target (IFETCH_ALIGN_CHECK_EN only).

Function
REQ-005 SHALL implement FSM states BOOT, RUN, FAULT; reset -> BOOT; BOOT -> RUN after one cycle; RUN -> FAULT on any fault; FAULT exits only by reset.
REQ-006 In BOOT, SHALL hold pc = RESET_PC, ir_valid = 0, no capture.
REQ-007 In RUN, "advance" = !ir_valid || ir_ready; on advance SHALL load ir <= instr, ir_pc <= pc, ir_valid <= 1, pc <= pc + 2.
REQ-008 When ir_valid && !ir_ready, SHALL hold pc, ir, ir_pc, ir_valid unchanged.
REQ-009 pc + 2 SHALL wrap modulo 2^16 (16'hFFFE -> 16'h0000); no flag.
REQ-010 redirect/call/ret SHALL be sampled only when ir_valid && ir_ready in RUN; otherwise ignored.
REQ-011 Sampled control priority: ret > call > redirect; lower-priority inputs that cycle SHALL be ignored.
REQ-012 On sampled redirect: pc <= redirect_pc, ir_valid <= 0 (one-cycle bubble; target instruction valid two cycles after redirect).
REQ-013 On sampled call: push ir_pc + 2 (mod 2^16), then act as redirect.
REQ-014 On sampled ret: pop top, pc <= popped value, ir_valid <= 0.
REQ-015 Call with RS_DEPTH entries held: no push, no pc change, rs_overflow <= 1, ir_valid <= 0, state <= FAULT.
REQ-016 Ret with stack empty: no pop, rs_underflow <= 1, ir_valid <= 0, state <= FAULT.
REQ-017 In FAULT: ir_valid = 0, pc frozen, stack frozen, all inputs ignored.
REQ-018 Return stack is LIFO; depth counter 0..RS_DEPTH; contents after pop are don't-care.

Reset
REQ-019 Asserting reset at any time, including mid-redirect or with stack partly full, SHALL immediately force: state BOOT, pc = RESET_PC, ir = 16'h0000, ir_pc = 16'h0000, ir_valid = 0, stack depth 0, rs_overflow = rs_underflow = misalign = 0.
REQ-020 Stack storage array SHALL need no reset; only the depth counter is reset.

Configuration
REQ-021 Macro IFETCH_ALIGN_CHECK_EN defined: sampled redirect/call with redirect_pc[0] = 1 SHALL set misalign <= 1, ir_valid <= 0, state <= FAULT, no push, pc unchanged.
REQ-022 Macro undefined: redirect_pc[0] SHALL be forced to 0 on use; misalign tied to 0.

Structure
REQ-023 Shared package forth_pkg SHALL hold WORD_W = 16, CODE_BASE = 16'h0000, DICT_BASE = 16'h1000, FSM state encoding; ifetch imports it.
REQ-024 Return stack SHALL be sub-module ifetch_rstack (push, pop, top, full, empty, RS_DEPTH parameter).

Verification
REQ-025 Reset, ir_ready = 1, memory word k = k: ir_pc sequence 0000, 0002, 0004 with ir = 0, 1, 2 on consecutive cycles from the 2nd cycle after reset release.
REQ-026 ir_ready = 0 for 3 cycles with ir_valid = 1: pc, ir, ir_pc stable; resume fetches next sequential address, no loss or duplicate.
REQ-027 call to 16'h1000 from ir_pc 16'h0010, then ret: ir_pc = 1000 after one bubble; after ret, ir_pc = 0012.
REQ-028 9 nested calls with RS_DEPTH = 8: rs_overflow = 1, state FAULT, ir_valid stays 0; ret on empty after reset: rs_underflow = 1.
REQ-029 ret and redirect to 16'h0100 same cycle with top = 16'h0040: pc = 0040.
REQ-030 With IFETCH_ALIGN_CHECK_EN, redirect to 16'h0101: misalign = 1, FAULT; without it, next ir_pc = 0100; reset asserted mid-bubble clears all flags and pc = RESET_PC.
